// File: rtl/spi_ram_gen2.sv
// SPI-style command RAM: 2-bit command + WIDTH-bit payload per rx_valid beat; registered reads.
// Optional build macro SPI_RAM_AUTO_INC_EN: post-increment wr/rd addresses on in-range accesses.
module spi_ram_gen2 #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [WIDTH+1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             tx_valid,
  output logic             err_addr
);

  localparam int unsigned     AddrW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [WIDTH:0]  DepthW = (WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    CmdWrAddr = 2'b00,
    CmdWrData = 2'b01,
    CmdRdAddr = 2'b10,
    CmdRdData = 2'b11
  } cmd_e;

  cmd_e             cmd;
  logic [WIDTH-1:0] payload;

  logic [WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             tx_valid_q, tx_valid_d;
  logic             err_q, err_d;

  logic             wr_in_range, rd_in_range;
  logic             mem_we;
  logic [AddrW-1:0] wr_idx, rd_idx;

  logic [WIDTH-1:0] mem_q [MEM_DEPTH];

  assign cmd     = cmd_e'(din[WIDTH+1:WIDTH]);
  assign payload = din[WIDTH-1:0];

  // Compare one bit wider so MEM_DEPTH == 2**WIDTH is representable.
  assign wr_in_range = {1'b0, wr_addr_q} < DepthW;
  assign rd_in_range = {1'b0, rd_addr_q} < DepthW;
  assign wr_idx      = wr_addr_q[AddrW-1:0];
  assign rd_idx      = rd_addr_q[AddrW-1:0];

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic [WIDTH-1:0] LastAddr = WIDTH'(MEM_DEPTH - 1);

  function automatic logic [WIDTH-1:0] next_addr(input logic [WIDTH-1:0] a);
    if (a == LastAddr) begin
      return '0;
    end
    return a + 1'b1;
  endfunction
`endif

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;

    if (rx_valid) begin
      unique case (cmd)
        CmdWrAddr: wr_addr_d = payload;
        CmdWrData: begin
          if (wr_in_range) begin
            mem_we = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
            wr_addr_d = next_addr(wr_addr_q);
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        CmdRdAddr: rd_addr_d = payload;
        CmdRdData: begin
          tx_valid_d = 1'b1;
          if (rd_in_range) begin
            dout_d = mem_q[rd_idx];
`ifdef SPI_RAM_AUTO_INC_EN
            rd_addr_d = next_addr(rd_addr_q);
`endif
          end else begin
            dout_d = '0;
            err_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx] <= payload;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign err_addr = err_q;

endmodule
